// File: rtl/serial_frame_rx.sv
// serial_frame_rx: receives start/data/parity/stop frames from a one-bit-per-clock
// stream and presents each recovered word on a valid/ready port, flagging parity
// errors, framing errors and dropped (overflowed) words.
module serial_frame_rx #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              x,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              par_err,
   output logic              frame_err,
   output logic              overflow
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic              par_bit;

   logic frame_done;
   logic frame_bad;
   logic accept;
   logic load;
   logic drop;

   // Even parity check: 1 means the data bits plus parity bit have odd weight.
   function automatic logic parity_fail(input logic [DATA_W-1:0] d, input logic p);
      return (^d) ^ p;
   endfunction

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode plus frame completion / load / drop qualifiers.
   always_comb begin
      state_nxt  = state;
      frame_done = 1'b0;
      frame_bad  = 1'b0;
      case (state)
         S_IDLE:   if (x) state_nxt = S_DATA;
         S_DATA:   if (bit_cnt == LAST_BIT) state_nxt = S_PARITY;
         S_PARITY: state_nxt = S_STOP;
         S_STOP: begin
            state_nxt = S_IDLE;
            if (x) frame_bad  = 1'b1;
            else   frame_done = 1'b1;
         end
         default:  state_nxt = S_IDLE;
      endcase
      accept = out_valid && out_ready;
      // A held word blocks the new one unless it is accepted on this same edge.
      load   = frame_done && (!out_valid || out_ready);
      drop   = frame_done && out_valid && !out_ready;
   end

   // Bit counter, shift register and captured parity bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
      end else begin
         case (state)
            S_IDLE: bit_cnt <= '0;
            S_DATA: begin
               shreg[bit_cnt] <= x;
               bit_cnt        <= bit_cnt + CNT_W'(1);
            end
            S_PARITY: par_bit <= x;
            default: ;
         endcase
      end
   end

   // Output word, valid handshake and one-cycle error pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         par_err   <= 1'b0;
         frame_err <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         frame_err <= frame_bad;
         overflow  <= drop;
         if (load) begin
            out_data  <= shreg;
            par_err   <= parity_fail(shreg, par_bit);
            out_valid <= 1'b1;
         end else if (accept) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx with DATA_W = 8.
module tb_serial_frame_rx;

   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              x;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              par_err;
   logic              frame_err;
   logic              overflow;

   int compared   = 0;
   int mismatched = 0;

   serial_frame_rx #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .x         (x),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .par_err   (par_err),
      .frame_err (frame_err),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one bit, let the next rising edge sample it, settle 1 time unit.
   task automatic send_bit(input logic b);
      x = b;
      @(posedge clk);
      #1;
   endtask

   // Full frame; out_ready is forced to rdy_stop just before the stop edge
   // when set_rdy is 1.
   task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                             input logic set_rdy, input logic rdy_stop);
      send_bit(1'b1);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(p);
      if (set_rdy) out_ready = rdy_stop;
      send_bit(stop);
      x = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      x = 1'b0;
      out_ready = 1'b0;

      // Reset held with x toggling
      for (int i = 0; i < 5; i++) send_bit(i[0]);
      chk("rst_data",  {24'd0, out_data}, 32'h00);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_perr",  {31'd0, par_err}, 32'd0);
      chk("rst_ferr",  {31'd0, frame_err}, 32'd0);
      chk("rst_ovf",   {31'd0, overflow}, 32'd0);
      x = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      chk("idle_valid", {31'd0, out_valid}, 32'd0);

      // Good frame 0xA5, ready high, with latency check
      out_ready = 1'b1;
      send_bit(1'b1);
      send_bit(1); send_bit(0); send_bit(1); send_bit(0);
      send_bit(0); send_bit(1); send_bit(0); send_bit(1);
      send_bit(1'b0);
      chk("a5_valid_before_stop", {31'd0, out_valid}, 32'd0);
      send_bit(1'b0);
      chk("a5_valid", {31'd0, out_valid}, 32'd1);
      chk("a5_data",  {24'd0, out_data}, 32'hA5);
      chk("a5_perr",  {31'd0, par_err}, 32'd0);
      chk("a5_ferr",  {31'd0, frame_err}, 32'd0);
      send_bit(1'b0);
      chk("a5_accepted", {31'd0, out_valid}, 32'd0);
      chk("a5_data_hold", {24'd0, out_data}, 32'hA5);

      // Parity error: 0x03 with parity bit 1
      out_ready = 1'b0;
      send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("p03_valid", {31'd0, out_valid}, 32'd1);
      chk("p03_data",  {24'd0, out_data}, 32'h03);
      chk("p03_perr",  {31'd0, par_err}, 32'd1);
      chk("p03_ferr",  {31'd0, frame_err}, 32'd0);
      out_ready = 1'b1;
      send_bit(1'b0);
      chk("p03_accepted", {31'd0, out_valid}, 32'd0);

      // Framing error: 0x5A, good parity, stop = 1
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("f5a_ferr",  {31'd0, frame_err}, 32'd1);
      chk("f5a_valid", {31'd0, out_valid}, 32'd0);
      chk("f5a_data",  {24'd0, out_data}, 32'h03);
      chk("f5a_ovf",   {31'd0, overflow}, 32'd0);
      send_bit(1'b0);
      chk("f5a_ferr_pulse", {31'd0, frame_err}, 32'd0);
      send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("g11_valid", {31'd0, out_valid}, 32'd1);
      chk("g11_data",  {24'd0, out_data}, 32'h11);
      chk("g11_perr",  {31'd0, par_err}, 32'd0);
      send_bit(1'b0);
      chk("g11_accepted", {31'd0, out_valid}, 32'd0);

      // Back-to-back with ready low: overflow on second frame
      out_ready = 1'b0;
      send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("b01_valid", {31'd0, out_valid}, 32'd1);
      chk("b01_data",  {24'd0, out_data}, 32'h01);
      send_frame(8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("b02_ovf",   {31'd0, overflow}, 32'd1);
      chk("b02_data",  {24'd0, out_data}, 32'h01);
      chk("b02_perr",  {31'd0, par_err}, 32'd0);
      chk("b02_valid", {31'd0, out_valid}, 32'd1);
      send_bit(1'b0);
      chk("b02_ovf_pulse", {31'd0, overflow}, 32'd0);
      chk("b02_valid_held", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      send_bit(1'b0);
      chk("b01_accepted", {31'd0, out_valid}, 32'd0);
      chk("b01_data_hold", {24'd0, out_data}, 32'h01);

      // Simultaneous accept and load
      out_ready = 1'b0;
      send_frame(8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("s10_data", {24'd0, out_data}, 32'h10);
      send_frame(8'h20, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("s20_data",  {24'd0, out_data}, 32'h20);
      chk("s20_valid", {31'd0, out_valid}, 32'd1);
      chk("s20_ovf",   {31'd0, overflow}, 32'd0);
      send_bit(1'b0);
      chk("s20_accepted", {31'd0, out_valid}, 32'd0);

      // Asynchronous reset mid-frame
      send_bit(1'b1);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      rst = 1'b1;
      #1;
      chk("mrst_data",  {24'd0, out_data}, 32'h00);
      chk("mrst_valid", {31'd0, out_valid}, 32'd0);
      #1;
      rst = 1'b0;
      x = 1'b0;
      for (int i = 0; i < 12; i++) begin
         send_bit(1'b0);
         chk("mrst_no_pulse", {29'd0, out_valid, frame_err, overflow}, 32'd0);
      end
      send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("mc3_valid", {31'd0, out_valid}, 32'd1);
      chk("mc3_data",  {24'd0, out_data}, 32'hC3);
      chk("mc3_perr",  {31'd0, par_err}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
